// File: rtl/pwm_pkg.sv
// Shared encodings and default parameters for the PWM sequencer family.
package pwm_pkg;

  localparam int unsigned PWM_W         = 32;
  localparam int unsigned PWM_RAMP_DIV  = 4;
  localparam int unsigned PWM_RAMP_STEP = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RAMP  = 2'b01,
    ST_RUN   = 2'b10,
    ST_FAULT = 2'b11
  } pwm_state_e;

endpackage

// File: rtl/pwm_sawtooth_l1.sv
// Sawtooth counter identical to the pwm_l1 counter; tick marks the last cycle of a period.
module pwm_sawtooth_l1 #(
  parameter int unsigned W = 32
) (
  input  logic         aclk,
  input  logic         reset,
  input  logic         ce,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = (cnt == period);

  // Wrap is not gated by ce so the boundary can never be skipped.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (ce) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pwm_seq_l1.sv
// Period/comparator sequencer for pwm_l1: shadowed setpoints, soft-start ramp, fault forcing.
module pwm_seq_l1
  import pwm_pkg::*;
#(
  parameter int unsigned W         = PWM_W,
  parameter int unsigned RAMP_DIV  = PWM_RAMP_DIV,
  parameter int unsigned RAMP_STEP = PWM_RAMP_STEP
) (
  input  logic         aclk,
  input  logic         reset,
  input  logic         ce,
  input  logic         enable,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_period,
  input  logic [W-1:0] cfg_duty,
  input  logic         fault,
  input  logic         fault_clr,
  output logic [W-1:0] pwm_period,
  output logic [W-1:0] pwm_comparator,
  output logic         period_tick,
  output logic [1:0]   state
);

  localparam int unsigned DIV_W = $clog2(RAMP_DIV) + 1;

  pwm_state_e   st;
  logic [W-1:0] target;
  logic [W-1:0] sh_period;
  logic [W-1:0] sh_duty;
  logic [DIV_W-1:0] div;

  logic         apply;
  logic         accept;
  logic [W-1:0] nxt_period;
  logic [W-1:0] nxt_target;
  logic [W:0]   eff_wide;
  logic [W-1:0] tgt_eff;
  logic [W:0]   step_sum;
  logic         ramp_hit;
  logic [W-1:0] ramp_val;

  assign state = st;

  pwm_sawtooth_l1 #(.W(W)) u_saw (
    .aclk   (aclk),
    .reset  (reset),
    .ce     (ce),
    .period (pwm_period),
    .tick   (period_tick)
  );

  // Clamp uses the values that will be live after this edge so a new setpoint takes effect at count 0.
  always_comb begin
    apply      = period_tick & ~cfg_ready;
    accept     = cfg_valid & cfg_ready;
    nxt_period = apply ? sh_period : pwm_period;
    nxt_target = apply ? sh_duty   : target;
    eff_wide   = {1'b0, nxt_period} + (W+1)'(1);
    if ({1'b0, nxt_target} < eff_wide) begin
      eff_wide = {1'b0, nxt_target};
    end
    // period+1 can exceed W bits only for an all-ones period; saturate instead of wrapping.
    tgt_eff  = eff_wide[W] ? '1 : eff_wide[W-1:0];
    step_sum = {1'b0, pwm_comparator} + (W+1)'(RAMP_STEP);
    ramp_hit = (step_sum >= {1'b0, tgt_eff});
    ramp_val = ramp_hit ? tgt_eff : step_sum[W-1:0];
  end

  // Shadow slot: cfg_ready low means the slot holds a setpoint waiting for the next boundary.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      pwm_period <= '0;
      target     <= '0;
      sh_period  <= '0;
      sh_duty    <= '0;
      cfg_ready  <= 1'b1;
    end else begin
      if (apply) begin
        pwm_period <= sh_period;
        target     <= sh_duty;
        cfg_ready  <= 1'b1;
      end
      if (accept) begin
        sh_period <= cfg_period;
        sh_duty   <= cfg_duty;
        cfg_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      st             <= ST_IDLE;
      pwm_comparator <= '0;
      div            <= '0;
    end else if (fault) begin
      st             <= ST_FAULT;
      pwm_comparator <= '0;
      div            <= '0;
    end else if (st == ST_FAULT) begin
      pwm_comparator <= '0;
      div            <= '0;
      if (fault_clr) begin
        st <= ST_IDLE;
      end
    end else if (!enable) begin
      st             <= ST_IDLE;
      pwm_comparator <= '0;
      div            <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          st             <= ST_RAMP;
          pwm_comparator <= '0;
          div            <= '0;
        end
        ST_RAMP: begin
          if (period_tick) begin
            if (pwm_comparator >= tgt_eff) begin
              pwm_comparator <= tgt_eff;
              st             <= ST_RUN;
            end else if (div == DIV_W'(RAMP_DIV - 1)) begin
              div            <= '0;
              pwm_comparator <= ramp_val;
              if (ramp_hit) begin
                st <= ST_RUN;
              end
            end else begin
              div <= div + DIV_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (period_tick) begin
            if (tgt_eff > pwm_comparator) begin
              st  <= ST_RAMP;
              div <= '0;
            end else begin
              pwm_comparator <= tgt_eff;
            end
          end
        end
        default: begin
          st             <= ST_IDLE;
          pwm_comparator <= '0;
          div            <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_seq_l1.sv
// Self-checking bench for pwm_seq_l1: directed scenarios plus random traffic against a reference model.
module tb_pwm_seq_l1;

  localparam int unsigned W  = 32;
  localparam int unsigned RD = 4;
  localparam int unsigned RS = 1;

  logic         aclk = 1'b0;
  logic         reset = 1'b1;
  logic         ce = 1'b1;
  logic         enable = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [W-1:0] cfg_period = '0;
  logic [W-1:0] cfg_duty = '0;
  logic         fault = 1'b0;
  logic         fault_clr = 1'b0;
  logic [W-1:0] pwm_period;
  logic [W-1:0] pwm_comparator;
  logic         period_tick;
  logic [1:0]   state;

  int total = 0;
  int bad = 0;

  // Reference model: counter, active setpoint, one-deep setpoint queue, converter phase.
  longint m_cnt, m_per, m_tgt, m_comp;
  longint q_per[$];
  longint q_duty[$];
  int     m_st;
  int     m_nb;

  pwm_seq_l1 #(.W(W), .RAMP_DIV(RD), .RAMP_STEP(RS)) dut (
    .aclk           (aclk),
    .reset          (reset),
    .ce             (ce),
    .enable         (enable),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_period     (cfg_period),
    .cfg_duty       (cfg_duty),
    .fault          (fault),
    .fault_clr      (fault_clr),
    .pwm_period     (pwm_period),
    .pwm_comparator (pwm_comparator),
    .period_tick    (period_tick),
    .state          (state)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_per = 0; m_tgt = 0; m_comp = 0;
    m_st = 0; m_nb = 0;
    q_per.delete();
    q_duty.delete();
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_next();
    bit     tick;
    bit     take;
    longint eff;
    tick = (m_cnt == m_per);
    take = cfg_valid && (q_per.size() == 0);
    if (tick && q_per.size() > 0) begin
      m_per = q_per.pop_front();
      m_tgt = q_duty.pop_front();
    end
    if (take) begin
      q_per.push_back(longint'(cfg_period));
      q_duty.push_back(longint'(cfg_duty));
    end
    m_cnt = tick ? 0 : m_cnt + (ce ? 1 : 0);
    eff = (m_tgt < m_per + 1) ? m_tgt : m_per + 1;
    if (eff > 64'hFFFF_FFFF) eff = 64'hFFFF_FFFF;
    if (fault) begin
      m_st = 3; m_comp = 0; m_nb = 0;
    end else if (m_st == 3) begin
      m_comp = 0;
      if (fault_clr) m_st = 0;
    end else if (!enable) begin
      m_st = 0; m_comp = 0; m_nb = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_comp = 0; m_nb = 0;
    end else if (tick && m_st == 1) begin
      if (m_comp >= eff) begin
        m_comp = eff; m_st = 2;
      end else begin
        m_nb++;
        if (m_nb % RD == 0) begin
          m_nb = 0;
          m_comp = (m_comp + RS >= eff) ? eff : m_comp + RS;
          if (m_comp == eff) m_st = 2;
        end
      end
    end else if (tick && m_st == 2) begin
      if (eff > m_comp) begin
        m_st = 1; m_nb = 0;
      end else begin
        m_comp = eff;
      end
    end
  endtask

  task automatic compare_all();
    chk("comparator", longint'(pwm_comparator), m_comp);
    chk("period", longint'(pwm_period), m_per);
    chk("tick", longint'(period_tick), longint'(m_cnt == m_per));
    chk("ready", longint'(cfg_ready), longint'(q_per.size() == 0));
    chk("state", longint'(state), longint'(m_st));
  endtask

  task automatic step();
    model_next();
    @(negedge aclk);
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Offer a setpoint for one accepted cycle, waiting a bounded time for a free slot.
  task automatic send_cfg(input longint p, input longint d);
    int waited = 0;
    while (!cfg_ready && waited < 200) begin
      step();
      waited++;
    end
    if (!cfg_ready) chk("cfg_slot_timeout", 0, 1);
    cfg_valid = 1'b1;
    cfg_period = W'(p);
    cfg_duty = W'(d);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge aclk);
    chk("rst_cmp", longint'(pwm_comparator), 0);
    chk("rst_state", longint'(state), 0);
    chk("rst_ready", longint'(cfg_ready), 1);
    reset = 1'b0;

    // Soft start to 5 of a 10-cycle period.
    enable = 1'b1;
    send_cfg(9, 5);
    steps(230);
    chk("t1_cmp", longint'(pwm_comparator), 5);
    chk("t1_state", longint'(state), 2);

    // Lower the target mid-period; applied at the next boundary.
    steps(4);
    send_cfg(9, 2);
    chk("t2_ready_low", longint'(cfg_ready), 0);
    steps(12);
    chk("t2_cmp", longint'(pwm_comparator), 2);

    // Oversized duty saturates at period+1; fault during the ramp.
    send_cfg(9, 50);
    steps(60);
    chk("t4_ramping", longint'(state), 1);
    fault = 1'b1;
    step();
    chk("t4_fault_cmp", longint'(pwm_comparator), 0);
    fault_clr = 1'b1;
    step();
    chk("t4_clr_ignored", longint'(state), 3);
    fault = 1'b0;
    step();
    fault_clr = 1'b0;
    chk("t4_idle", longint'(state), 0);
    step();
    chk("t4_reramp", longint'(state), 1);
    steps(450);
    chk("t3_sat_cmp", longint'(pwm_comparator), 10);
    chk("t3_sat_state", longint'(state), 2);

    // Period change 9 -> 19 with counter part-way through.
    send_cfg(19, 10);
    steps(80);
    chk("t5_period", longint'(pwm_period), 19);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      ce        = ($urandom_range(0, 9) != 0);
      enable    = ($urandom_range(0, 49) != 0) ? 1'b1 : ~enable;
      fault     = ($urandom_range(0, 39) == 0);
      fault_clr = ($urandom_range(0, 9) == 0);
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_period = W'($urandom_range(0, 12));
      cfg_duty   = W'($urandom_range(0, 16));
      step();
    end
    fault = 1'b0; fault_clr = 1'b0; cfg_valid = 1'b0; ce = 1'b1;
    enable = 1'b1;
    send_cfg(9, 5);
    steps(250);

    // Asynchronous reset pulse mid-cycle while running.
    reset = 1'b1;
    #1;
    chk("t6_cmp", longint'(pwm_comparator), 0);
    chk("t6_period", longint'(pwm_period), 0);
    chk("t6_state", longint'(state), 0);
    chk("t6_ready", longint'(cfg_ready), 1);
    model_reset();
    @(negedge aclk);
    reset = 1'b0;
    compare_all();
    steps(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
